uart_tx_fifo: RTL

Parametrised second-generation UART transmitter for the UART IP. A data-valid/ready handshake loads a FIFO, and the FIFO feeds a serialiser. The serialiser supports a programmable divisor, runtime character length of 5–8 bits, optional parity and 1 or 2 stop bits. The block sits between the register block and the TX pin and supersedes the fixed-table, single-byte transmitter.

---
 rtl/uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with an input FIFO. Characters are written through a
// valid/ready handshake into a FIFO. The FIFO feeds a serialiser that emits
// start bit, 5..8 data bits (LSB first), an optional parity bit and one or two
// stop bits. The bit period is baud_div+1 clocks.
//
// Character format and divisor are sampled when a character is popped. A
// frame in flight is therefore unaffected by later changes to these inputs.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> PARITY state present; par_en/par_odd honoured
//                      undefined -> no parity support; par_en/par_odd ignored
//
// Parameters:
//   DIV_W       divisor width in bits
//   FIFO_DEPTH  number of FIFO entries (power of two, >= 2)
//
// Ports:
//   clock       system clock
//   resetn      asynchronous active-low reset
//   uart_en     block enable; dropping it mid-frame aborts the frame
//   baud_div    bit period minus one, in clocks
//   data_len    data bits: 00=5, 01=6, 10=7, 11=8
//   par_en      parity bit enable
//   par_odd     1 = odd parity, 0 = even parity
//   stop2       1 = two stop bits
//   in_valid    write request
//   in_ready    write accepted when high (= !fifo_full)
//   in_data     character to send
//   TX          serial output, idles high
//   tx_busy     serialiser is not idle
//   tx_done     one-cycle pulse when the last stop bit completes
//   fifo_full   FIFO full flag
//   fifo_empty  FIFO empty flag
//   fifo_level  FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          uart_en,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    data_len,
    input  logic                          par_en,
    input  logic                          par_odd,
    input  logic                          stop2,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          TX,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t state;

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic [7:0]    head;
    logic          push;
    logic          pop;

    assign in_ready = ~fifo_full;
    assign push     = in_valid && in_ready;
    // The only pop point is the IDLE->START transition.
    assign pop      = (state == IDLE) && uart_en && !fifo_empty;
    assign head     = mem[rd_ptr];

    always_comb begin
        level_nxt = fifo_level;
        case ({push, pop})
            2'b10:   level_nxt = fifo_level + LW'(1);
            2'b01:   level_nxt = fifo_level - LW'(1);
            default: level_nxt = fifo_level;
        endcase
    end

    // Storage carries no reset; only the pointers and flags do.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers are AW bits wide, so incrementing wraps modulo FIFO_DEPTH.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= level_nxt;
            fifo_full  <= (level_nxt == LW'(FIFO_DEPTH));
            fifo_empty <= (level_nxt == '0);
        end
    end

    // -------------------------------------------------------------------------
    // Serialiser
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_l;
    logic [1:0]       len_l;
    logic             stop2_l;
    logic [2:0]       bit_cnt;
    logic             stop_cnt;
    logic [7:0]       shreg;
    logic             tx_q;
    logic             tick;
    logic             last_bit;

    // A bit period ends when the counter reaches the latched divisor.
    assign tick     = (state != IDLE) && (baud_cnt == div_l);
    // Index of the final data bit: data_len + 4 (5..8 bits).
    assign last_bit = (bit_cnt == ({1'b0, len_l} + 3'd4));
    assign TX       = tx_q;
    assign tx_busy  = (state != IDLE);

`ifdef UART_TX_PARITY_EN
    logic par_en_l;
    logic par_l;

    // Parity over the transmitted data bits only; bits above the character
    // length are masked off.
    function automatic logic calc_parity(input logic [7:0] d,
                                         input logic [1:0] len,
                                         input logic       odd);
        logic [7:0] mask;
        case (len)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return (^(d & mask)) ^ odd;
    endfunction
`else
    logic unused_par_cfg;
    assign unused_par_cfg = par_en ^ par_odd;
`endif

    // Shift register and computed parity are pure data; loaded on the pop.
    always_ff @(posedge clock) begin
        if (pop) begin
            shreg <= head;
`ifdef UART_TX_PARITY_EN
            par_l <= calc_parity(head, data_len, par_odd);
`endif
        end else if ((state == DATA) && tick && !last_bit) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    // TX is registered from the next state, so it changes on the same edge
    // as the state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            div_l    <= '0;
            len_l    <= 2'b00;
            stop2_l  <= 1'b0;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_l <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if ((state != IDLE) && !uart_en) begin
                // Abort: the popped character is dropped, no done pulse.
                state    <= IDLE;
                tx_q     <= 1'b1;
                baud_cnt <= '0;
            end else begin
                if ((state == IDLE) || tick) begin
                    baud_cnt <= '0;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (pop) begin
                            state    <= START;
                            tx_q     <= 1'b0;
                            div_l    <= baud_div;
                            len_l    <= data_len;
                            stop2_l  <= stop2;
                            bit_cnt  <= 3'd0;
                            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            par_en_l <= par_en;
`endif
                        end
                    end

                    START: begin
                        if (tick) begin
                            state <= DATA;
                            tx_q  <= shreg[0];
                        end
                    end

                    DATA: begin
                        if (tick) begin
                            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                                if (par_en_l) begin
                                    state <= PARITY;
                                    tx_q  <= par_l;
                                end else begin
                                    state <= STOP;
                                    tx_q  <= 1'b1;
                                end
`else
                                state <= STOP;
                                tx_q  <= 1'b1;
`endif
                            end else begin
                                // shreg shifts on this same edge, so the
                                // next bit is bit 1 of the current value.
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_q    <= shreg[1];
                            end
                        end
                    end

`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (tick) begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end
                    end
`endif

                    STOP: begin
                        if (tick) begin
                            if (stop2_l && !stop_cnt) begin
                                stop_cnt <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                tx_done <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
